// File: rtl/calc_if_pkg.sv
// Shared definitions for the calculator host sequencer.
//   calc_seq_state_t : sequencer FSM states
//   CALC_ADDR_*      : default byte addresses of the calculator words in data memory
//   CALC_WE_*        : levels of the active-low data-memory write strobe
package calc_if_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_A     = 4'd1,
    ST_WR_B     = 4'd2,
    ST_WR_OP    = 4'd3,
    ST_POLL     = 4'd4,
    ST_POLL_CHK = 4'd5,
    ST_RES      = 4'd6,
    ST_RES_CHK  = 4'd7,
    ST_RESP     = 4'd8
  } calc_seq_state_t;

  localparam logic [31:0] CALC_ADDR_A   = 32'd16;
  localparam logic [31:0] CALC_ADDR_B   = 32'd20;
  localparam logic [31:0] CALC_ADDR_OP  = 32'd0;
  localparam logic [31:0] CALC_ADDR_RES = 32'd24;

  localparam logic CALC_WE_ACTIVE = 1'b0;
  localparam logic CALC_WE_IDLE   = 1'b1;

endpackage

// File: rtl/calc_poll_timer.sv
// Poll-loop cycle counter.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count this cycle (saturates at TIMEOUT)
//   expired  : the current counted cycle is the TIMEOUT-th one
// TIMEOUT must be at least 1.
module calc_poll_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count while enabled until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q already holds the cycles counted before this one, so this cycle is
  // the TIMEOUT-th polling cycle once cnt_q reaches TIMEOUT-1.
  assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/calc_host_sequencer.sv
// Host-side sequencer for the calculator data-memory port of the processor.
// Accepts {A, B, opcode} on a valid/ready request channel, writes the three
// words into data memory, polls the opcode word until the program clears it,
// reads the result word and returns it on a valid/ready response channel.
//   CLK, RST                      : clock, asynchronous active-high reset
//   req_valid/req_ready/req_a/b/op: request channel (ready only in IDLE)
//   rsp_valid/rsp_ready           : response channel
//   rsp_result/rsp_timeout        : result word (0 on abort), abort flag
//   EntradaCalcu/addressCalcu     : memory write data / byte address
//   writeEnableCalcu              : active-low write strobe
//   resultadoCalcu                : read data for the previous cycle's address
module calc_host_sequencer
  import calc_if_pkg::*;
#(
  parameter logic [31:0] ADDR_A   = CALC_ADDR_A,
  parameter logic [31:0] ADDR_B   = CALC_ADDR_B,
  parameter logic [31:0] ADDR_OP  = CALC_ADDR_OP,
  parameter logic [31:0] ADDR_RES = CALC_ADDR_RES,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [31:0] EntradaCalcu,
  output logic [31:0] addressCalcu,
  output logic        writeEnableCalcu,
  input  logic [31:0] resultadoCalcu
);

  calc_seq_state_t state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     op_q, op_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_expired;

  // The counter restarts on the WR_OP -> POLL edge and runs through the loop.
  assign tmr_clr = (state_q == ST_WR_OP);
  assign tmr_en  = (state_q == ST_POLL) || (state_q == ST_POLL_CHK);

  calc_poll_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_poll_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state logic and operand/response capture.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          state_d = ST_WR_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_A:  state_d = ST_WR_B;
      ST_WR_B:  state_d = ST_WR_OP;
      ST_WR_OP: state_d = ST_POLL;
      ST_POLL:  state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        // A cleared opcode word wins over an expiring timer.
        if (resultadoCalcu == 32'd0) begin
          state_d = ST_RES;
        end else if (tmr_expired) begin
          rsp_result_d  = 32'd0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_RES: state_d = ST_RES_CHK;
      ST_RES_CHK: begin
        rsp_result_d  = resultadoCalcu;
        rsp_timeout_d = 1'b0;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= 32'd0;
      rsp_result_q  <= 32'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Memory port decoded from the registered state and latched operands only.
  always_comb begin
    EntradaCalcu     = 32'd0;
    addressCalcu     = 32'd0;
    writeEnableCalcu = CALC_WE_IDLE;
    case (state_q)
      ST_WR_A: begin
        EntradaCalcu     = a_q;
        addressCalcu     = ADDR_A;
        writeEnableCalcu = CALC_WE_ACTIVE;
      end
      ST_WR_B: begin
        EntradaCalcu     = b_q;
        addressCalcu     = ADDR_B;
        writeEnableCalcu = CALC_WE_ACTIVE;
      end
      ST_WR_OP: begin
        EntradaCalcu     = op_q;
        addressCalcu     = ADDR_OP;
        writeEnableCalcu = CALC_WE_ACTIVE;
      end
      ST_POLL: addressCalcu = ADDR_OP;
      ST_RES:  addressCalcu = ADDR_RES;
      default: addressCalcu = 32'd0;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_calc_host_sequencer.sv
// Directed self-checking bench for calc_host_sequencer (TIMEOUT = 8).
// A small data-memory model returns read data one cycle late; the "program"
// clears the opcode word from cycle done_at after acceptance on and supplies
// res_word at the result address.
module tb_calc_host_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [31:0] req_op = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic [31:0] EntradaCalcu;
  logic [31:0] addressCalcu;
  logic        writeEnableCalcu;
  logic [31:0] resultadoCalcu = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:7];
  int          cyc_since_acc = 0;
  int          done_at = 0;
  logic [31:0] res_word = 32'd0;

  always #5 CLK = ~CLK;

  calc_host_sequencer #(
    .TIMEOUT (8)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_op           (req_op),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_timeout      (rsp_timeout),
    .EntradaCalcu     (EntradaCalcu),
    .addressCalcu     (addressCalcu),
    .writeEnableCalcu (writeEnableCalcu),
    .resultadoCalcu   (resultadoCalcu)
  );

  // Data memory plus processor-program model.
  always @(posedge CLK) begin
    if (req_valid && req_ready) cyc_since_acc <= 1;
    else cyc_since_acc <= cyc_since_acc + 1;
    if (writeEnableCalcu == 1'b0) mem[addressCalcu[4:2]] <= EntradaCalcu;
    if (addressCalcu == 32'd0)
      resultadoCalcu <= (cyc_since_acc >= done_at) ? 32'd0 : mem[0];
    else if (addressCalcu == 32'd24)
      resultadoCalcu <= res_word;
    else
      resultadoCalcu <= mem[addressCalcu[4:2]];
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request and return one step after the acceptance edge (cycle 1).
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_wait: got %b want 1", req_ready);
    end
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Step until rsp_valid, bounded; cyc returns the cycle number it rose in.
  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (rsp_valid !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_timeout, writeEnableCalcu} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 1001", {req_ready, rsp_valid, rsp_timeout, writeEnableCalcu});
    end
    vectors++;
    if ({rsp_result, EntradaCalcu, addressCalcu} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_words: got %h/%h/%h want 0/0/0", rsp_result, EntradaCalcu, addressCalcu);
    end
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_single_op();
    int cyc;
    done_at = 10;
    res_word = 32'd109;
    do_req(32'd99, 32'd10, 32'd1);
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'd99, 32'd16, 1'b0}) begin
      miscompares++;
      $display("FAIL single_wr_a: got %0d@%0d we=%b want 99@16 we=0", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    step();
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'd10, 32'd20, 1'b0}) begin
      miscompares++;
      $display("FAIL single_wr_b: got %0d@%0d we=%b want 10@20 we=0", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    step();
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'd1, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_wr_op: got %0d@%0d we=%b want 1@0 we=0", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    step();
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'd0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL single_poll: got %0d@%0d we=%b want 0@0 we=1", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    wait_rsp(4, cyc);
    vectors++;
    if (cyc != 14) begin
      miscompares++;
      $display("FAIL single_latency: got cycle %0d want 14", cyc);
    end
    vectors++;
    if ({rsp_timeout, rsp_result} !== {1'b0, 32'd109}) begin
      miscompares++;
      $display("FAIL single_result: got to=%b res=%0d want to=0 res=109", rsp_timeout, rsp_result);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_immediate_done();
    int cyc;
    done_at = 0;
    res_word = 32'hDEADBEEF;
    rsp_ready = 1'b1;
    do_req(32'd7, 32'd8, 32'd0);
    step();
    step();
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL imm_wr_op: got %0d@%0d we=%b want 0@0 we=0", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    wait_rsp(3, cyc);
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL imm_latency: got cycle %0d want 8", cyc);
    end
    vectors++;
    if ({rsp_timeout, rsp_result} !== {1'b0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL imm_result: got to=%b res=%h want to=0 res=deadbeef", rsp_timeout, rsp_result);
    end
    step();
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL imm_same_cycle_ready: got rdy/vld=%b want 10", {req_ready, rsp_valid});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc;
    done_at = 1000000;
    res_word = 32'h0BAD0BAD;
    do_req(32'd3, 32'd4, 32'd5);
    wait_rsp(1, cyc);
    vectors++;
    if (cyc != 12) begin
      miscompares++;
      $display("FAIL to_latency: got cycle %0d want 12", cyc);
    end
    vectors++;
    if ({rsp_timeout, rsp_result} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL to_result: got to=%b res=%h want to=1 res=0", rsp_timeout, rsp_result);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({rsp_valid, writeEnableCalcu, addressCalcu, EntradaCalcu} !== {1'b1, 1'b1, 32'd0, 32'd0}) begin
        miscompares++;
        $display("FAIL to_idle_port: got vld=%b we=%b a=%h d=%h want 1 1 0 0", rsp_valid, writeEnableCalcu, addressCalcu, EntradaCalcu);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    done_at = 0;
    res_word = 32'h1234;
    rsp_ready = 1'b0;
    do_req(32'd1, 32'd2, 32'd3);
    wait_rsp(1, cyc);
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL bp_latency: got cycle %0d want 8", cyc);
    end
    req_a = 32'hA5;
    req_b = 32'hB6;
    req_op = 32'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, req_ready, rsp_timeout, rsp_result} !== {1'b1, 1'b0, 1'b0, 32'h1234}) begin
        miscompares++;
        $display("FAIL bp_hold: got vld=%b rdy=%b to=%b res=%h want 1 0 0 1234", rsp_valid, req_ready, rsp_timeout, rsp_result);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_idle_after_hs: got rdy/vld=%b want 10", {req_ready, rsp_valid});
    end
    res_word = 32'h55;
    step();
    req_valid = 1'b0;
    vectors++;
    if ({EntradaCalcu, addressCalcu, writeEnableCalcu} !== {32'hA5, 32'd16, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_second_wr_a: got %h@%0d we=%b want a5@16 we=0", EntradaCalcu, addressCalcu, writeEnableCalcu);
    end
    wait_rsp(1, cyc);
    vectors++;
    if ({cyc == 8, rsp_result} !== {1'b1, 32'h55}) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got cycle %0d res=%h want cycle 8 res=55", cyc, rsp_result);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    int cyc;
    done_at = 1000000;
    do_req(32'd11, 32'd22, 32'd9);
    step();
    step();
    step();
    step();
    RST = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_timeout, writeEnableCalcu, addressCalcu, EntradaCalcu} !== {4'b1001, 64'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_poll: got rdy=%b vld=%b to=%b we=%b a=%h d=%h want 1 0 0 1 0 0", req_ready, rsp_valid, rsp_timeout, writeEnableCalcu, addressCalcu, EntradaCalcu);
    end
    step();
    RST = 1'b0;
    step();
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_release: got rdy/vld=%b want 10", {req_ready, rsp_valid});
    end
    done_at = 0;
    res_word = 32'h77;
    do_req(32'd5, 32'd6, 32'd2);
    wait_rsp(1, cyc);
    vectors++;
    if ({cyc == 8, rsp_timeout, rsp_result} !== {1'b1, 1'b0, 32'h77}) begin
      miscompares++;
      $display("FAIL rst_fresh_op: got cycle %0d to=%b res=%h want cycle 8 to=0 res=77", cyc, rsp_timeout, rsp_result);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_immediate_done();
    test_timeout();
    test_back_to_back();
    test_reset_mid_poll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
